smpc_ctrl_n: RTL and testbench
==============================

SMPC_CTRL_N -- requirements
Module: smpc_ctrl_n

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning the number of controlled reset channels (1..6).
REQ-002 SHALL have parameter NO, default 32, meaning the OREG depth (16..32).
REQ-003 SHALL have parameter NSMEM, default 4, meaning the SMEM byte count (1..4).
REQ-004 SHALL have parameter T_SHORT, default 127, meaning the CE-cycle wait for short commands.
REQ-005 SHALL have parameter T_LONG, default 400000, meaning the CE-cycle wait for long commands (fits 20 bits).
REQ-006 CLK  in  1  system clock; single clock domain.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 CE  in  1  clock enable; all non-reset state advances only when CE=1.
REQ-009 A  in  6  word address; byte address = {A,1}.
REQ-010 DI/DO  in/out  8  write data / registered read data.
REQ-011 CS_N, RW_N  in  1 each  chip select and read/write strobe, active low.
REQ-012 SRES_N  in  1  reset button, active low.
REQ-013 AC  in  4  area code.
REQ-014 PAD1, PAD2  in  16 each  pad button states.
REQ-015 RES_N  out  NCH  per-channel reset, active low.
REQ-016 NMI_N, MIRQ_N  out  1 each  master NMI and interrupt, active low.

Function
REQ-017 Writes SHALL commit on the CE cycle where RW_N falls with CS_N=0: 0x01+2i to IREG[i] (i<7), 0x1F to COMREG, 0x63 to SF<=DI[0]; other addresses ignored.
REQ-018 Reads SHALL latch DO on the CE cycle where CS_N falls with RW_N=1: 0x21+2j to OREG[j] (j<NO), 0x61 to SR, 0x63 to {7'b0,SF}, anything else to 0.
REQ-019 The FSM SHALL have states IDLE, EXEC, WAIT, END, HOLD.
REQ-020 IDLE->EXEC SHALL occur when SF=1 and no SRES sequence is active; MIRQ_N=1 in IDLE.
REQ-021 EXEC SHALL decode COMREG as follows: 2k sets CH_ON(k) and 2k+1 sets CH_OFF(k) for k<NCH, with wait T_SHORT; 0x0D SYSRES drives all RES_N=0 and NMI_N=0 with wait T_LONG; 0x10 INTBACK; 0x17 SETSMEM with wait T_SHORT; 0x18 NMIREQ drives NMI_N=0 with wait T_SHORT; 0x19 RESENAB and 0x1A RESDISA with wait T_SHORT; any other code goes directly to END.
REQ-022 WAIT SHALL decrement the counter once per CE cycle and go to END when the counter reaches 0, so WAIT occupancy is exactly N CE cycles.
REQ-023 END SHALL write OREG[NO-1]<=COMREG, clear SF, apply the command effect, and go to IDLE (INTBACK with more data pending goes to HOLD instead).
REQ-024 Command effects: CH_ON(k) sets RES_N[k]=1; CH_OFF(k) sets RES_N[k]=0; SYSRES sets all RES_N=1 and NMI_N=1; SETSMEM loads SMEM[i]<=IREG[i] for i<NSMEM; NMIREQ sets NMI_N=1; RESENAB sets RESD=0; RESDISA sets RESD=1.
REQ-025 INTBACK with IREG[0][0]=1 SHALL wait T_SHORT, then load status: OREG[0]={0,RESD,000000}, OREG[9]={0000,AC}, OREG[10]={0000,RES_N[3:0]} zero-extended, OREG[12+i]=SMEM[i], all other OREG 0; then pulse MIRQ_N=0 for one CE cycle.
REQ-026 INTBACK with IREG[1][3]=1 SHALL set SR[5]=1 and enter HOLD; otherwise SR[5] SHALL remain 0.
REQ-027 INTBACK with IREG[0][0]=0 and IREG[1][3]=1 SHALL skip the status phase and load pad data immediately (REQ-029).
REQ-028 In HOLD, a write to IREG[0] with DI[7]=1 (break) SHALL clear SR[5] and SF and go to IDLE; DI[6]=1 (continue) SHALL wait T_SHORT, then load pad data; break SHALL win if both bits are set.
REQ-029 Pad data: OREG[0]=F1, [1]=02, [2]=PAD1[15:8], [3]=PAD1[7:0], [4]=F1, [5]=02, [6]=PAD2[15:8], [7]=PAD2[7:0]; then clear SR[5] and SF, pulse MIRQ_N=0 for one CE cycle, and go to IDLE.
REQ-030 SR[3] SHALL equal ~SRES_N, registered on each CE cycle; SR[0] SHALL be 1 when the FSM is not in IDLE.
REQ-031 SRES: SRES_N=0 with RESD=0 and no active sequence SHALL set NMI_N=0, load T_LONG, and mark the sequence active.
REQ-032 At count 0 the SRES sequence SHALL release NMI_N=1 and end only after SRES_N=1; commands SHALL be held off while it is active.
REQ-033 If SRES triggers while the FSM is not in IDLE, the current command SHALL complete first and SRES SHALL start the cycle after the FSM returns to IDLE.
REQ-034 A COMREG write while busy SHALL be stored, and that command SHALL execute on the next IDLE with SF=1.
REQ-035 The wait counter SHALL saturate at 0 and never wrap.

Reset
REQ-036 RST_N=0 SHALL clear COMREG, SR, SF, IREG, OREG, SMEM and DO, drive RES_N=all 0, NMI_N=0, MIRQ_N=1, RESD=1, and put the FSM in IDLE; asserting RST_N mid-command SHALL abort the command.
REQ-037 After reset release, NMI_N SHALL stay 0 until the first NMIREQ or SYSRES completes.

Verification
REQ-038 Write COMREG=0x02, SF=1 -> RES_N[1] rises after 127 WAIT CE cycles; SF reads 0; OREG[NO-1]=0x02.
REQ-039 COMREG=0x10 with IREG0=0x01, IREG1=0x08 -> status in OREG, SR[5]=1, one-cycle MIRQ_N pulse; IREG0=0x40 -> OREG[2..3]=PAD1, second MIRQ_N pulse, SR[5]=0.
REQ-040 INTBACK in HOLD, IREG0=0xC0 -> break wins: SR[5]=0, SF=0, no second MIRQ_N pulse.
REQ-041 RESENAB, then SRES_N=0 for 10 cycles -> NMI_N=0 for exactly T_LONG CE cycles; SF=1 during the sequence is not serviced until SRES_N=1.
REQ-042 COMREG=0x55 -> END next cycle, SF=0, outputs unchanged; COMREG=0x0D -> all RES_N=0 for T_LONG, then all 1.
REQ-043 RST_N pulse mid-WAIT -> all REQ-036 values, FSM IDLE.

Source files
------------

// File: rtl/smpc_ctrl_n.sv
// smpc_ctrl_n: system-manager controller. Host-visible IREG/COMREG/OREG/SR/SF
// register file, a command sequencer with a saturating wait counter, per-channel
// reset control, NMI/interrupt generation and a reset-button (SRES) sequence.
module smpc_ctrl_n #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned NO      = 32,
    parameter int unsigned NSMEM   = 4,
    parameter int unsigned T_SHORT = 127,
    parameter int unsigned T_LONG  = 400000
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           CE,
    input  logic [5:0]     A,
    input  logic [7:0]     DI,
    output logic [7:0]     DO,
    input  logic           CS_N,
    input  logic           RW_N,
    input  logic           SRES_N,
    input  logic [3:0]     AC,
    input  logic [15:0]    PAD1,
    input  logic [15:0]    PAD2,
    output logic [NCH-1:0] RES_N,
    output logic           NMI_N,
    output logic           MIRQ_N
);

    localparam int unsigned CW = 20;
    localparam int unsigned OW = (NO > 1) ? $clog2(NO) : 1;

    localparam logic [CW-1:0] TShortCnt  = CW'(T_SHORT);
    localparam logic [CW-1:0] TLongCnt   = CW'(T_LONG);
    localparam logic [7:0]    NumChCodes = 8'(2 * NCH);

    // Word addresses (byte address = {A,1})
    localparam logic [5:0] AddrComreg = 6'h0F;
    localparam logic [5:0] AddrOreg0  = 6'h10;
    localparam logic [5:0] AddrSr     = 6'h30;
    localparam logic [5:0] AddrSf     = 6'h31;

    localparam logic [7:0] CmdSysres  = 8'h0D;
    localparam logic [7:0] CmdIntback = 8'h10;
    localparam logic [7:0] CmdSetsmem = 8'h17;
    localparam logic [7:0] CmdNmireq  = 8'h18;
    localparam logic [7:0] CmdResenab = 8'h19;
    localparam logic [7:0] CmdResdisa = 8'h1A;

    typedef enum logic [2:0] {StIdle, StExec, StWait, StEnd, StHold} state_e;
    // What StEnd should do once the wait has elapsed
    typedef enum logic [1:0] {PhCmd, PhStatus, PhPad} phase_e;

    state_e          state_q;
    phase_e          phase_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      cmd_q;
    logic [7:0]      comreg_q;
    logic            sf_q;
    logic            sr5_q;
    logic            sr3_q;
    logic            resd_q;
    logic            sres_act_q;
    logic [NCH-1:0]  res_n_q;
    logic            nmi_n_q;
    logic            mirq_n_q;
    logic [7:0]      do_q;
    logic            cs_n_q;
    logic            rw_n_q;
    logic [7:0]      ireg_q [7];
    logic [7:0]      oreg_q [NO];
    logic [7:0]      smem_q [NSMEM];

    logic            wr_stb;
    logic            rd_stb;
    logic            sres_trig;
    logic [7:0]      sr;
    logic [7:0]      rd_data;
    logic [OW-1:0]   oidx;
    logic [NCH+3:0]  res_ext;
    logic [3:0]      res4;

    // Strobes fire on the CE cycle of the falling edge of RW_N (write) or CS_N (read)
    assign wr_stb    = CE && !CS_N && !RW_N && rw_n_q;
    assign rd_stb    = CE && !CS_N && RW_N && cs_n_q;
    assign sres_trig = (state_q == StIdle) && !SRES_N && !resd_q && !sres_act_q;

    assign sr      = {2'b00, sr5_q, 1'b0, sr3_q, 2'b00, state_q != StIdle};
    assign oidx    = OW'(A - AddrOreg0);
    assign res_ext = {4'b0000, res_n_q};
    assign res4    = res_ext[3:0];

    assign RES_N  = res_n_q;
    assign NMI_N  = nmi_n_q;
    assign MIRQ_N = mirq_n_q;
    assign DO     = do_q;

    // Read data selection for the host port
    always_comb begin
        rd_data = 8'h00;
        if (A >= AddrOreg0 && {1'b0, A} < 7'(16 + NO)) begin
            rd_data = oreg_q[oidx];
        end else if (A == AddrSr) begin
            rd_data = sr;
        end else if (A == AddrSf) begin
            rd_data = {7'b0, sf_q};
        end
    end

    // Bus strobe history and registered read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            do_q   <= 8'h00;
            cs_n_q <= 1'b1;
            rw_n_q <= 1'b1;
        end else if (CE) begin
            cs_n_q <= CS_N;
            rw_n_q <= RW_N;
            if (rd_stb) begin
                do_q <= rd_data;
            end
        end
    end

    // Host register writes, SRES sequence and command FSM with registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            phase_q    <= PhCmd;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            comreg_q   <= 8'h00;
            sf_q       <= 1'b0;
            sr5_q      <= 1'b0;
            sr3_q      <= 1'b0;
            resd_q     <= 1'b1;
            sres_act_q <= 1'b0;
            res_n_q    <= '0;
            nmi_n_q    <= 1'b0;
            mirq_n_q   <= 1'b1;
            for (int i = 0; i < 7; i++) ireg_q[i] <= 8'h00;
            for (int j = 0; j < NO; j++) oreg_q[j] <= 8'h00;
            for (int i = 0; i < NSMEM; i++) smem_q[i] <= 8'h00;
        end else if (CE) begin
            mirq_n_q <= 1'b1;
            sr3_q    <= !SRES_N;

            if (wr_stb) begin
                if (A < 6'd7) begin
                    ireg_q[A[2:0]] <= DI;
                end else if (A == AddrComreg) begin
                    comreg_q <= DI;
                end else if (A == AddrSf) begin
                    sf_q <= DI[0];
                end
            end

            // SRES sequence owns the counter; it only runs while the FSM idles
            if (sres_act_q) begin
                if (cnt_q > 1) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    cnt_q   <= '0;
                    nmi_n_q <= 1'b1;
                    if (cnt_q == '0 && SRES_N) begin
                        sres_act_q <= 1'b0;
                    end
                end
            end

            case (state_q)
                StIdle: begin
                    if (sres_trig) begin
                        nmi_n_q    <= 1'b0;
                        cnt_q      <= TLongCnt;
                        sres_act_q <= 1'b1;
                    end else if (sf_q && !sres_act_q) begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    cmd_q   <= comreg_q;
                    phase_q <= PhCmd;
                    if (comreg_q < NumChCodes) begin
                        cnt_q   <= TShortCnt;
                        state_q <= StWait;
                    end else begin
                        case (comreg_q)
                            CmdSysres: begin
                                res_n_q <= '0;
                                nmi_n_q <= 1'b0;
                                cnt_q   <= TLongCnt;
                                state_q <= StWait;
                            end
                            CmdIntback: begin
                                if (ireg_q[0][0]) begin
                                    cnt_q   <= TShortCnt;
                                    phase_q <= PhStatus;
                                    state_q <= StWait;
                                end else if (ireg_q[1][3]) begin
                                    phase_q <= PhPad;
                                    state_q <= StEnd;
                                end else begin
                                    state_q <= StEnd;
                                end
                            end
                            CmdNmireq: begin
                                nmi_n_q <= 1'b0;
                                cnt_q   <= TShortCnt;
                                state_q <= StWait;
                            end
                            CmdSetsmem, CmdResenab, CmdResdisa: begin
                                cnt_q   <= TShortCnt;
                                state_q <= StWait;
                            end
                            default: state_q <= StEnd;
                        endcase
                    end
                end
                StWait: begin
                    // Leave on the cycle the count reaches zero: N cycles in WAIT
                    if (cnt_q > 1) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= StEnd;
                    end
                end
                StEnd: begin
                    state_q <= StIdle;
                    sf_q    <= 1'b0;
                    case (phase_q)
                        PhStatus: begin
                            for (int j = 0; j < NO; j++) oreg_q[j] <= 8'h00;
                            oreg_q[0]  <= {1'b0, resd_q, 6'b000000};
                            oreg_q[9]  <= {4'b0000, AC};
                            oreg_q[10] <= {4'b0000, res4};
                            for (int i = 0; i < NSMEM; i++) oreg_q[12 + i] <= smem_q[i];
                            mirq_n_q <= 1'b0;
                            if (ireg_q[1][3]) begin
                                // More data pending: keep SF set until HOLD resolves
                                sr5_q   <= 1'b1;
                                sf_q    <= 1'b1;
                                state_q <= StHold;
                            end
                        end
                        PhPad: begin
                            oreg_q[0] <= 8'hF1;
                            oreg_q[1] <= 8'h02;
                            oreg_q[2] <= PAD1[15:8];
                            oreg_q[3] <= PAD1[7:0];
                            oreg_q[4] <= 8'hF1;
                            oreg_q[5] <= 8'h02;
                            oreg_q[6] <= PAD2[15:8];
                            oreg_q[7] <= PAD2[7:0];
                            sr5_q     <= 1'b0;
                            mirq_n_q  <= 1'b0;
                        end
                        default: begin
                            for (int k = 0; k < NCH; k++) begin
                                if (cmd_q < NumChCodes && cmd_q[3:1] == 3'(k)) begin
                                    res_n_q[k] <= ~cmd_q[0];
                                end
                            end
                            case (cmd_q)
                                CmdSysres: begin
                                    res_n_q <= '1;
                                    nmi_n_q <= 1'b1;
                                end
                                CmdSetsmem: begin
                                    for (int i = 0; i < NSMEM; i++) smem_q[i] <= ireg_q[i];
                                end
                                CmdNmireq:  nmi_n_q <= 1'b1;
                                CmdResenab: resd_q  <= 1'b0;
                                CmdResdisa: resd_q  <= 1'b1;
                                default: ;
                            endcase
                        end
                    endcase
                    oreg_q[NO-1] <= cmd_q;
                end
                StHold: begin
                    // Break (DI[7]) takes priority over continue (DI[6])
                    if (wr_stb && A == 6'd0) begin
                        if (DI[7]) begin
                            sr5_q   <= 1'b0;
                            sf_q    <= 1'b0;
                            state_q <= StIdle;
                        end else if (DI[6]) begin
                            cnt_q   <= TShortCnt;
                            phase_q <= PhPad;
                            state_q <= StWait;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_smpc_ctrl_n.sv
// tb_smpc_ctrl_n: directed vectors with hand-computed expectations for smpc_ctrl_n.
module tb_smpc_ctrl_n;

    localparam int unsigned NCH     = 4;
    localparam int unsigned NO      = 32;
    localparam int unsigned NSMEM   = 4;
    localparam int unsigned T_SHORT = 127;
    localparam int unsigned T_LONG  = 300;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           CE = 1'b1;
    logic [5:0]     A = 6'h00;
    logic [7:0]     DI = 8'h00;
    logic [7:0]     DO;
    logic           CS_N = 1'b1;
    logic           RW_N = 1'b1;
    logic           SRES_N = 1'b1;
    logic [3:0]     AC = 4'hA;
    logic [15:0]    PAD1 = 16'h1234;
    logic [15:0]    PAD2 = 16'hABCD;
    logic [NCH-1:0] RES_N;
    logic           NMI_N;
    logic           MIRQ_N;

    int n_vec = 0;
    int n_bad = 0;
    int nmi_lo = 0;
    int mirq_lo = 0;
    logic nmi_mon = 1'b0;

    smpc_ctrl_n #(
        .NCH(NCH), .NO(NO), .NSMEM(NSMEM), .T_SHORT(T_SHORT), .T_LONG(T_LONG)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .CE(CE), .A(A), .DI(DI), .DO(DO),
        .CS_N(CS_N), .RW_N(RW_N), .SRES_N(SRES_N), .AC(AC),
        .PAD1(PAD1), .PAD2(PAD2), .RES_N(RES_N), .NMI_N(NMI_N), .MIRQ_N(MIRQ_N)
    );

    always #5 CLK = ~CLK;

    // Mid-cycle low-level counters for NMI_N and MIRQ_N
    always @(negedge CLK) begin
        if (nmi_mon && !NMI_N) nmi_lo++;
        if (!MIRQ_N) mirq_lo++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Commit happens on the third edge (RW_N falls with CS_N low)
    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        tick(); A = a; DI = d; CS_N = 1'b0; RW_N = 1'b1;
        tick(); RW_N = 1'b0;
        tick(); RW_N = 1'b1; CS_N = 1'b1;
    endtask

    // DO latches on the third edge (CS_N falls with RW_N high)
    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        tick(); A = a; RW_N = 1'b1; CS_N = 1'b1;
        tick(); CS_N = 1'b0;
        tick(); d = DO; CS_N = 1'b1;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        int fall;
        int m0;

        // Reset state
        repeat (3) tick();
        chk("rst_res_n", 32'(RES_N), 32'h0);
        chk("rst_nmi_n", 32'(NMI_N), 32'h0);
        chk("rst_mirq_n", 32'(MIRQ_N), 32'h1);
        chk("rst_do", 32'(DO), 32'h0);
        RST_N = 1'b1;
        rd(6'h30, d); chk("rst_sr", 32'(d), 32'h00);
        rd(6'h2F, d); chk("rst_oreg31", 32'(d), 32'h00);

        // Writes without CE must not commit
        CE = 1'b0;
        wr(6'h31, 8'h01);
        CE = 1'b1;
        rd(6'h31, d); chk("ce_gate_sf", 32'(d), 32'h0);

        // CH_ON(1): busy seen in SR, RES_N[1] rises T_SHORT+3 edges after the SF commit
        wr(6'h0F, 8'h02);
        wr(6'h31, 8'h01);
        rd(6'h30, d); chk("chon_sr_busy", 32'(d), 32'h01);
        n = 3;
        while (!RES_N[1] && n < 1000) begin tick(); n++; end
        chk("chon_latency", 32'(n), 32'd130);
        chk("chon_res_n", 32'(RES_N), 32'h2);
        rd(6'h31, d); chk("chon_sf", 32'(d), 32'h0);
        rd(6'h2F, d); chk("chon_oreg31", 32'(d), 32'h02);

        // SYSRES: all RES_N low from EXEC, high again after T_LONG WAIT cycles
        wr(6'h0F, 8'h0D);
        wr(6'h31, 8'h01);
        n = 0; fall = 0;
        while (RES_N != 4'hF && n < 1000) begin
            tick(); n++;
            if (RES_N == 4'h0 && fall == 0) fall = n;
        end
        chk("sysres_fall", 32'(fall), 32'd2);
        chk("sysres_rise", 32'(n), 32'd303);
        chk("sysres_nmi_n", 32'(NMI_N), 32'h1);

        // SETSMEM from IREG0..3
        wr(6'h00, 8'h11); wr(6'h01, 8'h22); wr(6'h02, 8'h33); wr(6'h03, 8'h44);
        wr(6'h0F, 8'h17);
        wr(6'h31, 8'h01);
        repeat (T_SHORT + 10) tick();

        // INTBACK status phase with continue request
        wr(6'h00, 8'h01); wr(6'h01, 8'h08); wr(6'h0F, 8'h10);
        wr(6'h31, 8'h01);
        n = 0;
        while (MIRQ_N && n < 1000) begin tick(); n++; end
        chk("ib_mirq_latency", 32'(n), 32'd130);
        tick(); chk("ib_mirq_width", 32'(MIRQ_N), 32'h1);
        rd(6'h10, d); chk("ib_oreg0", 32'(d), 32'h40);
        rd(6'h19, d); chk("ib_oreg9", 32'(d), 32'h0A);
        rd(6'h1A, d); chk("ib_oreg10", 32'(d), 32'h0F);
        rd(6'h1C, d); chk("ib_oreg12", 32'(d), 32'h11);
        rd(6'h1F, d); chk("ib_oreg15", 32'(d), 32'h44);
        rd(6'h12, d); chk("ib_oreg2", 32'(d), 32'h00);
        rd(6'h30, d); chk("ib_sr_hold", 32'(d), 32'h21);

        // Continue: pad data after T_SHORT
        wr(6'h00, 8'h40);
        n = 0;
        while (MIRQ_N && n < 1000) begin tick(); n++; end
        chk("pad_mirq_latency", 32'(n), 32'd128);
        rd(6'h10, d); chk("pad_oreg0", 32'(d), 32'hF1);
        rd(6'h12, d); chk("pad_oreg2", 32'(d), 32'h12);
        rd(6'h13, d); chk("pad_oreg3", 32'(d), 32'h34);
        rd(6'h16, d); chk("pad_oreg6", 32'(d), 32'hAB);
        rd(6'h17, d); chk("pad_oreg7", 32'(d), 32'hCD);
        rd(6'h30, d); chk("pad_sr", 32'(d), 32'h00);
        rd(6'h31, d); chk("pad_sf", 32'(d), 32'h0);

        // Break wins over continue
        wr(6'h00, 8'h01);
        wr(6'h31, 8'h01);
        n = 0;
        while (MIRQ_N && n < 1000) begin tick(); n++; end
        chk("brk_first_pulse", 32'(n), 32'd130);
        wr(6'h00, 8'hC0);
        m0 = mirq_lo;
        repeat (200) tick();
        chk("brk_no_pulse", 32'(mirq_lo - m0), 32'd0);
        rd(6'h30, d); chk("brk_sr", 32'(d), 32'h00);
        rd(6'h31, d); chk("brk_sf", 32'(d), 32'h0);

        // IREG0[0]=0 with IREG1[3]=1: pad data straight away
        PAD1 = 16'h9876;
        wr(6'h31, 8'h01);
        n = 0;
        while (MIRQ_N && n < 1000) begin tick(); n++; end
        chk("direct_pad_latency", 32'(n), 32'd3);
        rd(6'h13, d); chk("direct_pad_oreg3", 32'(d), 32'h76);

        // RESENAB, then an SRES press with a command pending
        wr(6'h0F, 8'h19);
        wr(6'h31, 8'h01);
        repeat (T_SHORT + 10) tick();
        rd(6'h10, d);
        nmi_lo = 0; nmi_mon = 1'b1;
        SRES_N = 1'b0;
        wr(6'h0F, 8'h03);
        wr(6'h31, 8'h01);
        rd(6'h30, d); chk("sres_sr3", 32'(d), 32'h08);
        tick();
        SRES_N = 1'b1;
        repeat (T_LONG - 20) tick();
        chk("sres_nmi_low", 32'(NMI_N), 32'h0);
        chk("sres_cmd_held", 32'(RES_N), 32'hF);
        repeat (200) tick();
        nmi_mon = 1'b0;
        chk("sres_nmi_width", 32'(nmi_lo), 32'(T_LONG));
        chk("sres_cmd_after", 32'(RES_N), 32'hD);

        // Unknown command: END right after EXEC, no output effect
        wr(6'h0F, 8'h55);
        wr(6'h31, 8'h01);
        rd(6'h30, d); chk("unk_sr_busy", 32'(d), 32'h01);
        rd(6'h30, d); chk("unk_sr_idle", 32'(d), 32'h00);
        rd(6'h31, d); chk("unk_sf", 32'(d), 32'h0);
        rd(6'h2F, d); chk("unk_oreg31", 32'(d), 32'h55);
        chk("unk_res_n", 32'(RES_N), 32'hD);
        chk("unk_nmi_n", 32'(NMI_N), 32'h1);

        // Reset in the middle of a WAIT
        wr(6'h0F, 8'h02);
        wr(6'h31, 8'h01);
        repeat (50) tick();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_res_n", 32'(RES_N), 32'h0);
        chk("mid_rst_nmi_n", 32'(NMI_N), 32'h0);
        chk("mid_rst_mirq_n", 32'(MIRQ_N), 32'h1);
        chk("mid_rst_do", 32'(DO), 32'h0);
        repeat (2) tick();
        RST_N = 1'b1;
        rd(6'h30, d); chk("mid_rst_sr", 32'(d), 32'h00);
        rd(6'h31, d); chk("mid_rst_sf", 32'(d), 32'h0);
        rd(6'h2F, d); chk("mid_rst_oreg31", 32'(d), 32'h00);
        repeat (200) tick();
        chk("mid_rst_aborted", 32'(RES_N), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
